// File: rtl/pc_debug_pkg.sv
// pc_debug_pkg: constants and FSM state type shared by both ends of the debug serial link
package pc_debug_pkg;
    localparam int DBG_WORD_W = 32;
    localparam int DBG_CNT_W  = 5;
    typedef enum logic {IDLE, RECV} dbg_state_t;
endpackage

// File: rtl/pc_debug_rx_if.sv
// pc_debug_rx_if: valid/ready read port carrying received debug words
// Signals: rd_valid (word available), rd_ready (consumer accepts), rd_data (head word).
// master = word source (receiver), slave = consumer.
interface pc_debug_rx_if;
    logic                              rd_valid;
    logic                              rd_ready;
    logic [pc_debug_pkg::DBG_WORD_W-1:0] rd_data;
    modport master (output rd_valid, output rd_data, input rd_ready);
    modport slave  (input rd_valid, input rd_data, output rd_ready);
endinterface

// File: rtl/pc_debug_rx_fifo.sv
// dbg_rx_fifo: received-word FIFO that overwrites its oldest entry when pushed while full
// Ports: clk, rst_n (async active-low), clr (sync clear of pointers), push/wdata (write),
//        pop (consume head, ignored when empty), rdata (head word), full, empty,
//        ovf_pulse (a word was lost this cycle).
module dbg_rx_fifo
    import pc_debug_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clr,
    input  logic                  push,
    input  logic                  pop,
    input  logic [DBG_WORD_W-1:0] wdata,
    output logic [DBG_WORD_W-1:0] rdata,
    output logic                  full,
    output logic                  empty,
    output logic                  ovf_pulse
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] ONE = 1;
    logic [AW:0]           wptr, rptr;
    logic [DBG_WORD_W-1:0] mem [DEPTH];
    logic                  do_pop, adv_r;
    assign empty = wptr == rptr;
    assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign rdata = mem[rptr[AW-1:0]];
    assign do_pop = pop && !empty;
    // A push into a full FIFO lands on the oldest slot, so the read pointer must move too
    assign adv_r = do_pop || (push && full);
    assign ovf_pulse = push && full && !do_pop;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr <= '0;
            rptr <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (clr) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (push) mem[wptr[AW-1:0]] <= wdata;
            if (push) wptr <= wptr + ONE;
            if (adv_r) rptr <= rptr + ONE;
        end
    end
endmodule

// File: rtl/pc_debug_rx.sv
// pc_debug_rx: debug serial receiver (start bit + 32 data bits MSB first) feeding a lossy FIFO
// Ports: clk, rst_n (async active-low), sleep (sync clear of FIFO, FSM, overflow),
//        debug_serial_in (line), rd (pc_debug_rx_if.master read port),
//        overflow (sticky word-lost flag), rx_busy (frame in progress),
//        frame_cnt (completed frames, wrapping).
// Build option: define PC_DEBUG_RX_SYNC_EN to insert a 2-flop input synchronizer.
module pc_debug_rx
    import pc_debug_pkg::*;
#(
    parameter int FIFO_DEPTH  = 4,
    parameter int FRAME_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   sleep,
    input  logic                   debug_serial_in,
    pc_debug_rx_if.master          rd,
    output logic                   overflow,
    output logic                   rx_busy,
    output logic [FRAME_CNT_W-1:0] frame_cnt
);
    localparam logic [DBG_CNT_W-1:0]   CNT_ONE = 1;
    localparam logic [FRAME_CNT_W-1:0] FRM_ONE = 1;
    dbg_state_t            state;
    logic [DBG_CNT_W-1:0]  bit_cnt;
    logic [DBG_WORD_W-2:0] shift;
    logic                  line, push, pop, full, empty, ovf_pulse;
    logic [DBG_WORD_W-1:0] wdata;
`ifdef PC_DEBUG_RX_SYNC_EN
    logic [1:0] sync;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sync <= '0;
        else sync <= {sync[0], debug_serial_in};
    end
    assign line = sync[1];
`else
    assign line = debug_serial_in;
`endif
    // Only the 31 earlier bits are stored; the final bit joins the word as it is pushed
    assign wdata = {shift, line};
    assign push = (state == RECV) && (bit_cnt == '1) && !sleep;
    assign pop = rd.rd_valid && rd.rd_ready;
    assign rd.rd_valid = !empty;
    assign rx_busy = state == RECV;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            bit_cnt   <= '0;
            shift     <= '0;
            frame_cnt <= '0;
        end else if (sleep) begin
            state   <= IDLE;
            bit_cnt <= '0;
            shift   <= '0;
        end else if (state == IDLE) begin
            state   <= line ? RECV : IDLE;
            bit_cnt <= '0;
        end else begin
            shift   <= {shift[DBG_WORD_W-3:0], line};
            bit_cnt <= bit_cnt + CNT_ONE;
            if (bit_cnt == '1) begin
                state     <= IDLE;
                frame_cnt <= frame_cnt + FRM_ONE;
            end
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) overflow <= 1'b0;
        else if (sleep) overflow <= 1'b0;
        else if (ovf_pulse && full) overflow <= 1'b1;
    end
    dbg_rx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (sleep),
        .push      (push),
        .pop       (pop),
        .wdata     (wdata),
        .rdata     (rd.rd_data),
        .full      (full),
        .empty     (empty),
        .ovf_pulse (ovf_pulse)
    );
endmodule

// File: tb/tb_pc_debug_rx.sv
// tb_pc_debug_rx: directed self-checking bench for pc_debug_rx
module tb_pc_debug_rx;
`ifdef PC_DEBUG_RX_SYNC_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 0;
`endif
    logic        clk = 0;
    logic        rst_n = 0;
    logic        sleep = 0;
    logic        ser = 0;
    logic        overflow, rx_busy;
    logic [15:0] frame_cnt;
    int          n_chk = 0;
    int          n_fail = 0;
    pc_debug_rx_if rif ();
    pc_debug_rx #(.FIFO_DEPTH(4), .FRAME_CNT_W(16)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .sleep           (sleep),
        .debug_serial_in (ser),
        .rd              (rif.master),
        .overflow        (overflow),
        .rx_busy         (rx_busy),
        .frame_cnt       (frame_cnt)
    );
    always #5 clk = ~clk;
    typedef struct {
        logic [31:0] word;
        logic [31:0] exp_data;
        logic [15:0] exp_cnt;
    } vec_t;
    vec_t vecs[6];
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask
    task automatic drive(input logic b);
        @(negedge clk);
        ser = b;
    endtask
    task automatic idle(input int n);
        repeat (n) drive(1'b0);
    endtask
    task automatic send_frame(input logic [31:0] w);
        drive(1'b1);
        for (int i = 31; i >= 0; i--) drive(w[i]);
    endtask
    task automatic read_expect(input string name, input logic [31:0] exp);
        chk({name, "_valid"}, 32'(rif.rd_valid), 32'd1);
        chk({name, "_data"}, rif.rd_data, exp);
        rif.rd_ready = 1'b1;
        @(negedge clk);
        rif.rd_ready = 1'b0;
    endtask
    initial begin
        logic bits[$];
        logic [31:0] burst[3];
        logic [31:0] w;
        int lows;
        vecs[0] = '{32'hA5A5_1234, 32'hA5A5_1234, 16'd1};
        vecs[1] = '{32'h0000_0001, 32'h0000_0001, 16'd2};
        vecs[2] = '{32'h8000_0000, 32'h8000_0000, 16'd3};
        vecs[3] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 16'd4};
        vecs[4] = '{32'h0000_0000, 32'h0000_0000, 16'd5};
        vecs[5] = '{32'h3C96_E10F, 32'h3C96_E10F, 16'd6};
        rif.rd_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_valid", 32'(rif.rd_valid), 32'd0);
        chk("rst_data", rif.rd_data, 32'd0);
        chk("rst_ovf", 32'(overflow), 32'd0);
        chk("rst_busy", 32'(rx_busy), 32'd0);
        chk("rst_cnt", 32'(frame_cnt), 32'd0);
        rst_n = 1'b1;
        idle(2);
        // single frames with the consumer always ready: word appears, then is popped
        rif.rd_ready = 1'b1;
        for (int v = 0; v < 6; v++) begin
            send_frame(vecs[v].word);
            for (int k = 0; k < LAT; k++) begin
                idle(1);
                chk("lat_early", 32'(rif.rd_valid), 32'd0);
            end
            idle(1);
            chk("vec_valid", 32'(rif.rd_valid), 32'd1);
            chk("vec_data", rif.rd_data, vecs[v].exp_data);
            chk("vec_cnt", 32'(frame_cnt), 32'(vecs[v].exp_cnt));
            idle(1);
            chk("vec_popped", 32'(rif.rd_valid), 32'd0);
        end
        rif.rd_ready = 1'b0;
        idle(2);
        // three back-to-back frames, nothing read
        burst[0] = 32'h0000_0001;
        burst[1] = 32'h8000_0000;
        burst[2] = 32'hFFFF_FFFF;
        for (int k = 0; k < 3; k++) begin
            bits.push_back(1'b1);
            for (int i = 31; i >= 0; i--) bits.push_back(burst[k][i]);
        end
        lows = 0;
        for (int j = 0; j < bits.size(); j++) begin
            @(negedge clk);
            if (j > LAT && !rx_busy) lows++;
            ser = bits[j];
        end
        idle(LAT + 1);
        chk("b2b_busy_lows", 32'(lows), 32'd2);
        chk("b2b_ovf", 32'(overflow), 32'd0);
        chk("b2b_cnt", 32'(frame_cnt), 32'd9);
        for (int k = 0; k < 3; k++) read_expect("b2b", burst[k]);
        chk("b2b_empty", 32'(rif.rd_valid), 32'd0);
        // six frames into a depth-4 FIFO: two oldest lost
        for (int k = 0; k < 6; k++) send_frame(32'(k));
        idle(LAT + 1);
        chk("ovf_set", 32'(overflow), 32'd1);
        for (int k = 2; k < 6; k++) read_expect("ovf_rd", 32'(k));
        chk("ovf_empty", 32'(rif.rd_valid), 32'd0);
        chk("ovf_sticky", 32'(overflow), 32'd1);
        sleep = 1'b1;
        idle(1);
        sleep = 1'b0;
        chk("ovf_sleep_clr", 32'(overflow), 32'd0);
        chk("sleep_cnt_held", 32'(frame_cnt), 32'd15);
        // full FIFO with a pop coinciding with the 5th push
        for (int k = 10; k < 14; k++) send_frame(32'(k));
        drive(1'b1);
        for (int i = 31; i >= 0; i--) drive(w_bit(32'd14, i));
        idle(LAT);
        rif.rd_ready = 1'b1;
        @(negedge clk);
        rif.rd_ready = 1'b0;
        chk("full_pp_ovf", 32'(overflow), 32'd0);
        for (int k = 11; k < 15; k++) read_expect("full_pp_rd", 32'(k));
        chk("full_pp_empty", 32'(rif.rd_valid), 32'd0);
        chk("full_pp_cnt", 32'(frame_cnt), 32'd20);
        // sleep in the middle of a frame
        w = 32'hA5A4_0000;
        drive(1'b1);
        for (int i = 31; i >= 16; i--) drive(w[i]);
        @(negedge clk);
        ser = 1'b0;
        sleep = 1'b1;
        @(negedge clk);
        sleep = 1'b0;
        idle(LAT + 1);
        chk("slp_valid", 32'(rif.rd_valid), 32'd0);
        chk("slp_busy", 32'(rx_busy), 32'd0);
        chk("slp_cnt", 32'(frame_cnt), 32'd20);
        send_frame(32'hDEAD_BEEF);
        idle(LAT + 1);
        read_expect("slp_next", 32'hDEAD_BEEF);
        chk("slp_next_cnt", 32'(frame_cnt), 32'd21);
        // a start bit seen only while sleep is high is ignored
        @(negedge clk);
        sleep = 1'b1;
        ser = 1'b1;
        idle(LAT + 1);
        sleep = 1'b0;
        idle(LAT + 1);
        chk("slp_start_busy", 32'(rx_busy), 32'd0);
        chk("slp_start_valid", 32'(rif.rd_valid), 32'd0);
        // reset mid-frame, then resume
        drive(1'b1);
        for (int i = 31; i >= 20; i--) drive(1'b0);
        #2 rst_n = 1'b0;
        @(negedge clk);
        ser = 1'b0;
        chk("mid_rst_busy", 32'(rx_busy), 32'd0);
        chk("mid_rst_cnt", 32'(frame_cnt), 32'd0);
        chk("mid_rst_valid", 32'(rif.rd_valid), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        idle(2);
        send_frame(32'h1357_9BDF);
        idle(LAT + 1);
        read_expect("post_rst", 32'h1357_9BDF);
        chk("post_rst_cnt", 32'(frame_cnt), 32'd1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
    function automatic logic w_bit(input logic [31:0] w, input int i);
        return w[i];
    endfunction
endmodule

// File: doc/pc_debug_rx.md
PC_DEBUG_RX -- requirements
Module: pc_debug_rx

Interface
REQ-001 The module SHALL have parameter FIFO_DEPTH, default 4, giving the number of received-word FIFO entries; it SHALL be a power of two and at least 2.
REQ-002 The module SHALL have parameter FRAME_CNT_W, default 16, giving the width of the frame counter.
REQ-003 clk  input  1  single clock; all logic SHALL be on its rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 sleep  input  1  synchronous clear of FIFO, FSM and flags.
REQ-006 debug_serial_in  input  1  debug serial line from the transmitter.
REQ-007 rd_ready  input  1  consumer accepts the head word.
REQ-008 rd_valid  output  1  FIFO is not empty.
REQ-009 rd_data  output  32  head-of-FIFO word.
REQ-010 overflow  output  1  sticky flag: a word was lost to a full FIFO.
REQ-011 rx_busy  output  1  a frame is being received.
REQ-012 frame_cnt  output  FRAME_CNT_W  count of completed frames, wrapping.

Function
REQ-013 Line protocol SHALL be: idle low; frame = one high start cycle followed by 32 data cycles, MSB first, one bit per clk, with no gap required between frames.
REQ-014 The FSM SHALL have exactly two states, IDLE and RECV.
REQ-015 IDLE: sampled line 1 SHALL move the FSM to RECV with bit_cnt=0; sampled line 0 SHALL keep the FSM in IDLE.
REQ-016 RECV: each cycle SHALL shift the sampled bit into the LSB of a 32-bit shift register and increment a 5-bit bit_cnt.
REQ-017 In RECV with bit_cnt==31, the completed word {shift[30:0], sampled bit} SHALL be pushed into the FIFO at that edge, frame_cnt SHALL increment (wrapping), and the FSM SHALL return to IDLE.
REQ-018 Latency SHALL be: rd_valid high in the cycle after the last data bit is sampled, with an empty FIFO and no sync stage.
REQ-019 A start bit sampled in the cycle immediately after the last data bit SHALL begin a new frame, so back-to-back frames are received losslessly.
REQ-020 rx_busy SHALL equal (state==RECV).
REQ-021 Read handshake: a pop SHALL occur when rd_valid && rd_ready; rd_data SHALL be stable while rd_valid && !rd_ready.
REQ-022 FIFO pointers SHALL be log2(FIFO_DEPTH)+1 bits wide; full = low bits equal and MSB differ; empty = pointers equal.
REQ-023 Push when full without a pop SHALL overwrite the oldest entry, advancing both pointers, and SHALL set overflow.
REQ-024 Push and pop in the same cycle, full or not, SHALL complete both and SHALL NOT set overflow.
REQ-025 Pop when empty SHALL have no effect.
REQ-026 overflow SHALL remain set until reset or sleep.
REQ-027 sleep SHALL take priority over all other events: pointers cleared, FSM to IDLE, partial frame discarded, overflow cleared; frame_cnt SHALL be held.
REQ-028 A line 1 sampled while sleep is high SHALL NOT start a frame.

Reset
REQ-029 During reset, the FSM SHALL be IDLE and bit_cnt, shift register, pointers, FIFO entries and frame_cnt SHALL be 0.
REQ-030 During reset, outputs SHALL be: rd_valid=0, rd_data=0, overflow=0, rx_busy=0.
REQ-031 Reset asserted mid-frame SHALL discard the frame; reception SHALL resume at the next start bit after release.

Configuration
REQ-032 The macro PC_DEBUG_RX_SYNC_EN SHALL control an input synchronizer.
REQ-033 With PC_DEBUG_RX_SYNC_EN defined, debug_serial_in SHALL pass through a 2-flop synchronizer (reset to 0) before the FSM, adding exactly 2 cycles of latency.
REQ-034 Without PC_DEBUG_RX_SYNC_EN, the FSM SHALL sample debug_serial_in directly (same clock domain as the transmitter).

Structure
REQ-035 A shared package pc_debug_pkg SHALL hold the constants DBG_WORD_W=32 and DBG_CNT_W=5 and the FSM state enum typedef, for use by both ends of the link.
REQ-036 The FIFO SHALL be a sub-module dbg_rx_fifo (parameter DEPTH; push, pop, wdata, rdata, full, empty, ovf_pulse); the FSM and shifter SHALL stay in the top.

Verification
REQ-037 Frame 1 + 0xA5A5_1234 MSB first, rd_ready=1 -> rd_valid high 1 cycle after the last bit, rd_data=0xA5A5_1234, frame_cnt=1.
REQ-038 Three back-to-back frames 0x1, 0x8000_0000, 0xFFFF_FFFF, rd_ready=0 -> FIFO holds all three in order, overflow=0, rx_busy never drops between frames except the single start cycle.
REQ-039 Six frames 0..5, rd_ready=0, FIFO_DEPTH=4 -> reads yield 2,3,4,5 and overflow=1 until sleep.
REQ-040 FIFO full (4 words) and rd_ready=1 on the push cycle of a 5th frame -> oldest word popped, new word stored, overflow stays 0.
REQ-041 sleep pulsed at bit 15 of a frame -> rd_valid=0, rx_busy=0, no word pushed; the following frame 0xDEAD_BEEF is received correctly.
REQ-042 With PC_DEBUG_RX_SYNC_EN defined, the REQ-037 stimulus -> same data, rd_valid 2 cycles later than without the macro.
